// File: rtl/sram_sample_streamer.sv
// Streams 16-bit samples from an asynchronous SRAM into a small FIFO and
// hands them out one per codec request, looping between START_ADDR and END_ADDR.
module sram_sample_streamer #(
  parameter logic [19:0] START_ADDR = 20'h00000,
  parameter logic [19:0] END_ADDR   = 20'hFFFFF,
  parameter int          DEPTH      = 8
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        play,
  input  logic        rewind,
  input  logic        sample_req,
  input  logic [15:0] SRAM_DQ,
  output logic [19:0] SRAM_ADDR,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        underrun,
  output logic [4:0]  fifo_level
);

  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] DEPTH_L = 5'(DEPTH);

  typedef enum logic [1:0] {IDLE, ADDR, WAIT, CAPTURE} state_t;

  state_t             state_q, state_d;
  logic [19:0]        addr_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]         level_q;
  logic [15:0]        mem [DEPTH];
  logic [15:0]        sample_p1;
  logic               vld_p1;
  logic               underrun_q;
  logic               empty, push, pop;

  function automatic logic [19:0] next_addr(input logic [19:0] a);
    return (a == END_ADDR) ? START_ADDR : a + 20'd1;
  endfunction

  // A started read is always pushed: occupancy can only fall while it is in flight.
  always_comb begin
    empty = (level_q == 5'd0);
    push  = (state_q == CAPTURE) && !rewind;
    pop   = sample_req && !rewind && !empty;
  end

  always_comb begin
    state_d = state_q;
    if (rewind) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (play && (level_q < DEPTH_L)) state_d = ADDR;
        ADDR:    state_d = WAIT;
        WAIT:    state_d = CAPTURE;
        CAPTURE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= START_ADDR;
    end else begin
      state_q <= state_d;
      if (rewind)    addr_q <= START_ADDR;
      else if (push) addr_q <= next_addr(addr_q);
    end
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= 5'd0;
      underrun_q <= 1'b0;
    end else if (rewind) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= 5'd0;
      underrun_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      level_q <= level_q + {4'd0, push} - {4'd0, pop};
      if (sample_req && empty) underrun_q <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr_q] <= SRAM_DQ;
  end

  // Output stage: popped word appears one cycle after the request.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_p1 <= 16'd0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= pop;
      if (pop) sample_p1 <= mem[rd_ptr_q];
    end
  end

  assign SRAM_ADDR    = addr_q;
  assign SRAM_CE_N    = 1'b0;
  assign SRAM_UB_N    = 1'b0;
  assign SRAM_LB_N    = 1'b0;
  assign SRAM_WE_N    = 1'b1;
  assign SRAM_OE_N    = (state_q == IDLE);
  assign sample_out   = sample_p1;
  assign sample_valid = vld_p1;
  assign underrun     = underrun_q;
  assign fifo_level   = level_q;

endmodule

// File: tb/tb_sram_sample_streamer.sv
// Randomized and directed bench for sram_sample_streamer against a queue-based
// model; a second instance with a tiny address window checks loop playback.
module tb_sram_sample_streamer;

  logic        Clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        play = 1'b0, rewind = 1'b0, sample_req = 1'b0;
  logic [15:0] key = 16'h0000;

  logic [19:0] addr, w_addr;
  logic        ce_n, ub_n, lb_n, oe_n, we_n;
  logic        w_ce_n, w_ub_n, w_lb_n, w_oe_n, w_we_n;
  logic [15:0] dq, w_dq, s_out, w_out;
  logic        s_vld, w_vld, und, w_und;
  logic [4:0]  lvl, w_lvl;

  assign dq   = addr[15:0] ^ key;
  assign w_dq = w_addr[15:0];

  always #5 Clk = ~Clk;

  sram_sample_streamer dut (
    .Clk(Clk), .reset_n(reset_n), .play(play), .rewind(rewind), .sample_req(sample_req),
    .SRAM_DQ(dq), .SRAM_ADDR(addr), .SRAM_CE_N(ce_n), .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n),
    .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n), .sample_out(s_out), .sample_valid(s_vld),
    .underrun(und), .fifo_level(lvl));

  sram_sample_streamer #(.START_ADDR(20'h00010), .END_ADDR(20'h00012), .DEPTH(4)) dut_w (
    .Clk(Clk), .reset_n(reset_n), .play(play), .rewind(rewind), .sample_req(sample_req),
    .SRAM_DQ(w_dq), .SRAM_ADDR(w_addr), .SRAM_CE_N(w_ce_n), .SRAM_UB_N(w_ub_n),
    .SRAM_LB_N(w_lb_n), .SRAM_OE_N(w_oe_n), .SRAM_WE_N(w_we_n), .sample_out(w_out),
    .sample_valid(w_vld), .underrun(w_und), .fifo_level(w_lvl));

  int n_tests = 0, n_fail = 0;

  // Reference model: FIFO as a queue, read progress as a cycle count within a 4-cycle read.
  logic [15:0] q[$];
  logic [19:0] m_addr;
  int          m_ph;
  logic [15:0] m_out;
  logic        m_vld, m_und;
  logic [15:0] w_exp;
  int          w_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_addr = 20'h0; m_ph = 0; m_out = 16'h0; m_vld = 1'b0; m_und = 1'b0;
    w_exp = 16'h0010;
  endtask

  task automatic model_step();
    int sz;
    sz = q.size();
    if (rewind) begin
      q.delete();
      m_addr = 20'h0; m_ph = 0; m_und = 1'b0; m_vld = 1'b0;
      w_exp = 16'h0010;
    end else begin
      m_vld = 1'b0;
      if (sample_req) begin
        if (sz > 0) begin m_out = q.pop_front(); m_vld = 1'b1; end
        else m_und = 1'b1;
      end
      if (m_ph == 3) begin
        q.push_back(m_addr[15:0] ^ key);
        m_addr = (m_addr == 20'hFFFFF) ? 20'h0 : m_addr + 20'd1;
        m_ph = 0;
      end else if (m_ph > 0) m_ph++;
      else if (play && sz < 8) m_ph = 1;
    end
  endtask

  task automatic compare();
    chk("oe_n",  oe_n, (m_ph == 0));
    chk("addr",  addr, m_addr);
    chk("level", lvl, q.size());
    chk("valid", s_vld, m_vld);
    chk("out",   s_out, m_out);
    chk("undr",  und, m_und);
    if (w_vld) begin
      chk("wrap", w_out, w_exp);
      w_exp = (w_exp == 16'h0012) ? 16'h0010 : w_exp + 16'd1;
      w_cnt++;
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_step();
    @(negedge Clk);
    compare();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("rst_oe", oe_n, 1'b1);
    chk("rst_addr", addr, 20'h0);
    chk("rst_lvl", lvl, 5'd0);
    chk("rst_out", s_out, 16'h0);
    chk("rst_vld", s_vld, 1'b0);
    chk("rst_und", und, 1'b0);
    chk("rst_pins", {ce_n, ub_n, lb_n, we_n}, 4'b0001);
    chk("rst_waddr", w_addr, 20'h10);
    @(posedge Clk);
    @(negedge Clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_for(input int ph, input logic [19:0] a, input logic use_a, input int sz);
    int k;
    for (k = 0; k < 300; k++) begin
      if (m_ph == ph && (!use_a || m_addr == a) && (sz < 0 || q.size() == sz)) break;
      cyc();
    end
    if (k == 300) chk("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1;
    do_reset();

    // Fill: 8 reads then idle.
    play = 1'b1;
    repeat (45) cyc();
    chk("fill_lvl", lvl, 5'd8);
    chk("fill_addr", addr, 20'h8);
    chk("fill_oe", oe_n, 1'b1);

    // Drain three samples, each followed by a refill read.
    for (int k = 0; k < 3; k++) begin
      sample_req = 1'b1; cyc(); sample_req = 1'b0;
      chk("drain_vld", s_vld, 1'b1);
      chk("drain_out", s_out, k);
      cyc();
      chk("drain_vld0", s_vld, 1'b0);
      repeat (8) cyc();
    end
    repeat (6) cyc();
    chk("refill_addr", addr, 20'hB);
    chk("refill_lvl", lvl, 5'd8);

    // Underrun on an empty FIFO, cleared by rewind.
    play = 1'b0;
    do_reset();
    sample_req = 1'b1; cyc(); sample_req = 1'b0;
    chk("und_set", und, 1'b1);
    chk("und_vld", s_vld, 1'b0);
    chk("und_out", s_out, 16'h0);
    rewind = 1'b1; cyc(); rewind = 1'b0;
    chk("und_clr", und, 1'b0);

    // Pop on the capture edge with four words stored.
    do_reset();
    play = 1'b1;
    wait_for(3, 20'h0, 1'b0, 4);
    sample_req = 1'b1; cyc(); sample_req = 1'b0;
    chk("sim_lvl", lvl, 5'd4);
    chk("sim_out", s_out, 16'h0);
    chk("sim_vld", s_vld, 1'b1);

    // Rewind while waiting on address 5.
    do_reset();
    wait_for(2, 20'h5, 1'b1, -1);
    rewind = 1'b1; cyc(); rewind = 1'b0;
    chk("rew_lvl", lvl, 5'd0);
    chk("rew_addr", addr, 20'h0);
    chk("rew_oe", oe_n, 1'b1);
    wait_for(1, 20'h0, 1'b0, -1);
    chk("rew_next", addr, 20'h0);

    // Reset in the middle of a read.
    wait_for(1, 20'h0, 1'b0, -1);
    do_reset();

    // Continuous streaming on the small window.
    w_cnt = 0;
    for (int i = 0; i < 90; i++) begin
      sample_req = (i % 6 == 0);
      cyc();
    end
    sample_req = 1'b0;
    chk("wrap_n", (w_cnt >= 10), 1'b1);

    // Randomized traffic.
    key = 16'($urandom);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      play       = ($urandom % 8) != 0;
      sample_req = ($urandom % 4) == 0;
      rewind     = ($urandom % 97) == 0;
      if ($urandom % 500 == 0) begin
        rewind = 1'b0;
        do_reset();
      end
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_sample_streamer.md
SRAM_SAMPLE_STREAMER -- requirements
Module: sram_sample_streamer

Interface
REQ-001 The block SHALL have parameter START_ADDR, default 20'h00000, meaning the first sample word address and the wrap target.
REQ-002 The block SHALL have parameter END_ADDR, default 20'hFFFFF, meaning the last sample word address before wrap.
REQ-003 The block SHALL have parameter DEPTH, default 8 (power of two, 2..16), meaning the sample FIFO depth in 16-bit words.
REQ-004 Ports SHALL be: Clk  in  1  sole clock, all logic on rising edge.
REQ-005 Ports SHALL be: reset_n  in  1  reset, asynchronous and active-low.
REQ-006 Ports SHALL be: play  in  1  level; 1 enables SRAM prefetch.
REQ-007 Ports SHALL be: rewind  in  1  one-cycle pulse; restarts playback at START_ADDR.
REQ-008 Ports SHALL be: sample_req  in  1  one-cycle pulse from the codec side, once per audio sample period.
REQ-009 Ports SHALL be: SRAM_DQ  in  16  SRAM read data.
REQ-010 Ports SHALL be: SRAM_ADDR  out  20  SRAM word address.
REQ-011 Ports SHALL be: SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N  out  1 each  SRAM controls, active-low.
REQ-012 Ports SHALL be: sample_out  out  16  last delivered sample.
REQ-013 Ports SHALL be: sample_valid  out  1  one-cycle pulse when sample_out updates.
REQ-014 Ports SHALL be: underrun  out  1  sticky flag; a request arrived while the FIFO was empty.
REQ-015 Ports SHALL be: fifo_level  out  5  current FIFO occupancy, 0..DEPTH.

Function
REQ-016 SRAM_CE_N, SRAM_UB_N and SRAM_LB_N SHALL be driven constant 0; SRAM_WE_N SHALL be driven constant 1.
REQ-017 The read FSM SHALL have states IDLE, ADDR, WAIT and CAPTURE.
REQ-018 In IDLE, if play=1 and fifo_level<DEPTH, the FSM SHALL go to ADDR; otherwise it SHALL stay in IDLE.
REQ-019 ADDR SHALL go to WAIT, WAIT SHALL go to CAPTURE, and CAPTURE SHALL go to IDLE, unconditionally.
REQ-020 SRAM_OE_N SHALL be 0 in ADDR, WAIT and CAPTURE, and 1 in IDLE.
REQ-021 SRAM_ADDR SHALL be registered and held stable from ADDR through CAPTURE.
REQ-022 On the clock edge leaving CAPTURE, SRAM_DQ SHALL be pushed into the FIFO.
REQ-023 On that same edge, SRAM_ADDR SHALL become SRAM_ADDR+1, or START_ADDR if SRAM_ADDR==END_ADDR (loop playback).
REQ-024 At most one read SHALL be in flight; one read occupies 4 cycles, so the peak fill rate is 1 word per 4 cycles.
REQ-025 A read started when fifo_level<DEPTH SHALL always be pushed, because occupancy cannot rise during a read.
REQ-026 Deasserting play during ADDR, WAIT or CAPTURE SHALL NOT abort the read: it completes and is pushed, and no further read starts.
REQ-027 On sample_req=1 with the FIFO not empty, the head word SHALL be popped into sample_out, with sample_valid=1 for exactly the next cycle (1-cycle latency).
REQ-028 On sample_req=1 with the FIFO empty, underrun SHALL be set to 1, sample_out SHALL hold its value, and sample_valid SHALL stay 0.
REQ-029 A push and a pop in the same cycle SHALL both take effect and leave fifo_level unchanged.
REQ-030 A pop from an empty FIFO that coincides with a push SHALL count as an underrun; the pushed word SHALL be retained.
REQ-031 FIFO pointers SHALL wrap modulo DEPTH; the FIFO SHALL never drop or duplicate a word.
REQ-032 On rewind=1 (synchronous; highest priority, above push and pop), the block SHALL flush the FIFO (fifo_level=0).
REQ-033 On rewind=1, SRAM_ADDR SHALL become START_ADDR, the FSM SHALL go to IDLE, and any in-flight read SHALL be discarded without a push.
REQ-034 On rewind=1, underrun SHALL be cleared, and any sample_req in that cycle SHALL be ignored (no pop, no underrun).
REQ-035 underrun SHALL clear only on reset or rewind.

Reset
REQ-036 On reset_n=0, asynchronously: state=IDLE, SRAM_ADDR=START_ADDR, SRAM_OE_N=1, FIFO pointers=0, fifo_level=0, sample_out=0, sample_valid=0, underrun=0.
REQ-037 Reset asserted mid-read SHALL abandon the read with no push.
REQ-038 After reset_n rises, the first read SHALL start no earlier than the first rising edge at which play=1 is sampled.

Verification
REQ-039 Fill: SRAM model returns the address as data, play=1, no sample_req -> reads of addr 0..7 occur, SRAM_OE_N=1 thereafter, fifo_level=8, no 9th read.
REQ-040 Drain: after the fill, 3 sample_req pulses 10 cycles apart -> sample_out 0x0000, 0x0001, 0x0002, each with a 1-cycle sample_valid; refill reads addr 8, 9, 10.
REQ-041 Wrap: START_ADDR=0x10, END_ADDR=0x12, continuous streaming -> delivered samples 0x10, 0x11, 0x12, 0x10, 0x11, ...
REQ-042 Underrun: play=0, sample_req pulse at reset exit -> underrun=1, sample_valid=0, sample_out=0; then rewind pulse -> underrun=0.
REQ-043 Simultaneous: fifo_level=4 with a sample_req on the CAPTURE edge -> fifo_level stays 4 and the popped word is the oldest.
REQ-044 Mid-operation: rewind during WAIT at addr 0x5 -> no push, fifo_level=0, next read at START_ADDR; reset_n low during ADDR -> all outputs at reset values immediately.
